// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - round-robin arbiter with registered one-hot grant held until done/withdraw
// Optional hold timeout with one-cycle expired pulse when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter3 #(
    parameter int N        = 3,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    done,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            expired
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            expired_q, expired_d;

    logic [N-1:0]    req_hi;
    logic [N-1:0]    req_sel;
    logic [ID_W-1:0] win_id;
    logic [N-1:0]    win_onehot;
    logic            own_done;
    logic            own_req;
    logic            timeout;

    // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
    always_comb begin
        req_hi = '0;
        for (int i = 0; i < N; i++) begin
            req_hi[i] = req[i] && (ID_W'(i) >= ptr_q);
        end
        req_sel = (|req_hi) ? req_hi : req;
        win_id  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_sel[i]) begin
                win_id = ID_W'(i);
            end
        end
        win_onehot = {{(N-1){1'b0}}, 1'b1} << win_id;
    end

    assign own_done = |(done & gnt_q);
    assign own_req  = |(req & gnt_q);

`ifdef RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == ST_GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_GRANT && state_d == ST_GRANT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = ^{MAX_HOLD[0], CNT_W[0]};
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        expired_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_GRANT;
                    gnt_d    = win_onehot;
                    gnt_id_d = win_id;
                    ptr_d    = (win_id == ID_W'(N - 1)) ? '0 : win_id + 1'b1;
                end
            end
            ST_GRANT: begin
                if (own_done || !own_req || timeout) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    // A normal release on the timeout edge is not reported as expiry.
                    expired_d = timeout && !own_done && own_req;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            expired_q <= expired_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == ST_GRANT);
    assign expired = expired_q;

endmodule

// File: tb/tb_rr_arbiter3.sv
// tb/tb_rr_arbiter3.sv - scoreboard bench for rr_arbiter3 (covers RR_ARB_TIMEOUT_EN when defined)
module tb_rr_arbiter3;

    localparam int N        = 3;
    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] req = '0;
    logic [2:0] done = '0;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expired;

    rr_arbiter3 #(.N(3), .ID_W(2), .MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .expired (expired)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [6:0] exp_q[$];

    bit         m_busy;
    int         m_ptr;
    logic [1:0] m_id;
    int         m_cnt;
    bit         m_exp;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_id   = '0;
        m_cnt  = 0;
        m_exp  = 1'b0;
    endtask

    function automatic logic [2:0] model_gnt();
        return m_busy ? (3'b001 << m_id) : 3'b000;
    endfunction

    task automatic model_step(input logic [2:0] r, input logic [2:0] d);
        bit         found;
        bit         rel;
        bit         to;
        logic [1:0] idx;
        m_exp = 1'b0;
        found = 1'b0;
        if (!m_busy) begin
            if (r != 3'b000) begin
                for (int i = 0; i < N; i++) begin
                    idx = 2'((m_ptr + i) % N);
                    if (!found && r[idx]) begin
                        found = 1'b1;
                        m_id  = idx;
                    end
                end
                m_busy = 1'b1;
                m_ptr  = (int'(m_id) + 1) % N;
                m_cnt  = 0;
            end
        end else begin
            rel = d[m_id] || !r[m_id];
            to  = TO_EN && (m_cnt == MAX_HOLD - 1);
            if (rel || to) begin
                m_busy = 1'b0;
                m_exp  = to && !rel;
                m_id   = '0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic [2:0] r, input logic [2:0] d, input string tag);
        req  = r;
        done = d;
        model_step(r, d);
        exp_q.push_back({model_gnt(), m_id, m_busy, m_exp});
        @(posedge clk);
        #1;
        check_val(tag, {gnt, gnt_id, busy, expired}, exp_q.pop_front());
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        check_val("async_reset", {gnt, gnt_id, busy, expired}, 7'd0);
        @(posedge clk);
        #1;
        check_val("reset_hold", {gnt, gnt_id, busy, expired}, 7'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] seq_exp [4];
        int         run;
        bit         ended;
        logic [2:0] r;
        logic [2:0] d;

        seq_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_state", {gnt, gnt_id, busy, expired}, 7'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) step(3'b000, 3'b000, "idle");

        for (int g = 0; g < 4; g++) begin
            step(3'b111, 3'b000, "rr_grant");
            check_val("rr_seq", gnt, seq_exp[g]);
            step(3'b111, 3'b000, "rr_hold");
            step(3'b111, model_gnt(), "rr_done");
        end
        step(3'b000, 3'b000, "rr_idle");

        pulse_reset();
        step(3'b100, 3'b000, "wrap_g2");
        check_val("wrap_first", gnt, 3'b100);
        step(3'b100, 3'b100, "wrap_rel");
        step(3'b101, 3'b000, "wrap_g0");
        check_val("wrap_second", gnt, 3'b001);
        step(3'b101, 3'b001, "wrap_rel2");
        step(3'b000, 3'b000, "wrap_idle");

        step(3'b010, 3'b000, "nopre_g1");
        step(3'b011, 3'b000, "nopre_h1");
        check_val("nopre_hold1", gnt, 3'b010);
        step(3'b011, 3'b000, "nopre_h2");
        check_val("nopre_hold2", gnt, 3'b010);
        step(3'b011, 3'b010, "nopre_rel");
        step(3'b011, 3'b000, "nopre_g0");
        check_val("nopre_next", gnt, 3'b001);
        step(3'b011, 3'b001, "nopre_rel2");
        step(3'b000, 3'b000, "nopre_idle");

        step(3'b010, 3'b000, "mid_g1");
        check_val("mid_grant", gnt, 3'b010);
        pulse_reset();
        step(3'b011, 3'b000, "post_rst");
        check_val("post_rst_gnt", gnt, 3'b001);
        step(3'b011, 3'b001, "post_rst_rel");
        step(3'b000, 3'b000, "post_rst_idle");

        step(3'b100, 3'b000, "pulse_g");
        check_val("pulse_grant", gnt, 3'b100);
        step(3'b000, 3'b000, "pulse_rel");
        step(3'b010, 3'b000, "both_g");
        step(3'b000, 3'b010, "both_rel");
        step(3'b000, 3'b000, "both_idle");
        step(3'b001, 3'b000, "nonown_g");
        step(3'b001, 3'b110, "nonown_ign");
        step(3'b001, 3'b001, "nonown_rel");
        step(3'b000, 3'b000, "nonown_idle");

        run   = 0;
        ended = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(3'b001, 3'b000, "hold");
            if (!ended) begin
                if (gnt == 3'b001) run++;
                else if (run > 0) ended = 1'b1;
            end
        end
        check_val("hold_len", run, TO_EN ? MAX_HOLD : 12);
        step(3'b000, 3'b000, "hold_end");
        step(3'b000, 3'b000, "hold_idle");

        for (int i = 0; i < 80; i++) begin
            r = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step(r, d, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter3.md
# rr_arbiter3

Round-robin arbiter that shares one single-owner resource, such as a register-rotation datapath or a shared bus port, among `N` requesters. It accepts level requests and issues one registered one-hot grant. The grant is held until the owner signals completion, then priority rotates past the last winner. The block sits between the requesting units and the shared resource's enable/select logic.

## Interface
- `N`, 3, number of requesters (2..8)
- `ID_W`, 2, width of encoded grant index; must satisfy 2^ID_W ≥ N
- `MAX_HOLD`, 8, maximum grant length in cycles; used only when `RR_ARB_TIMEOUT_EN` is defined; must be ≥ 1
- `CNT_W`, 4, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD

- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  N  level request, one bit per requester
- `done`  in  N  completion strobe from the current owner; bits of non-owners are ignored
- `gnt`  out  N  registered one-hot grant, or all zero
- `gnt_id`  out  ID_W  encoded index of the current owner; 0 when idle
- `busy`  out  1  high while in GRANT
- `expired`  out  1  one-cycle pulse when a grant is force-released by timeout

## Operation
- States:
  - IDLE: `gnt`=0, `busy`=0.
  - GRANT: exactly one `gnt` bit is high.
- Priority pointer `ptr` (range 0..N-1) names the highest-priority requester. Search order is `ptr`, `ptr`+1, …, wrapping modulo N.
- IDLE → GRANT:
  - Taken on any edge where `req` ≠ 0.
  - Winner k is the first set bit of `req` in search order.
  - The same edge sets `gnt`=1<<k, `gnt_id`=k, `busy`=1 and `ptr`=(k+1) mod N.
- IDLE with `req`=0: the block stays in IDLE and `ptr` is unchanged.
- GRANT → IDLE (release) is taken on an edge where any of the following holds for owner k:
  - `done[k]`=1.
  - `req[k]`=0, meaning the owner withdrew.
  - The timeout fires (see Configuration).
- On release, `gnt` and `gnt_id` are cleared on the same edge.
- Requests from non-owners during GRANT are ignored; no pre-emption.
- `done` arriving together with a dropped `req` counts as one release.
- Pointer wrap: after requester N-1 wins, `ptr` becomes 0.
- Reset values: state=IDLE, `ptr`=0, `gnt`=0, `gnt_id`=0, `busy`=0, `expired`=0, hold counter=0.
- Asserting `reset_n` mid-grant drops `gnt` immediately (asynchronously). Arbitration restarts with requester 0 as highest priority.

## Timing
- Grant latency: a request sampled at edge t in IDLE produces `gnt` visible after edge t.
- Release latency: `done[k]` sampled at edge t clears `gnt` after edge t.
- The earliest next grant is after edge t+1, so there is always at least one idle cycle between owners.
- A single-cycle `req` pulse in IDLE is granted. If it is already low at the next edge, the grant releases there, giving a 1-cycle grant.
- Fairness: with all N requesters continuously active, each requester is granted once every N grants.
- All outputs are driven directly from registers; there is no combinational path from input to output.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - A hold counter clears on entry to GRANT and increments on each GRANT cycle.
  - When the counter equals MAX_HOLD-1 and no `done`/withdraw occurs, that edge force-releases the grant and sets `expired`=1 for exactly one cycle.
  - If `done` coincides with the timeout edge, the release counts as normal and `expired` stays 0.
- Not defined:
  - No counter is built and `expired` is tied to 0.
  - A grant is held indefinitely until `done` or withdraw.

## Test plan
- Reset, then `req`=3'b000 for 5 cycles → `gnt`=0, `busy`=0, `gnt_id`=0 throughout.
- `req`=3'b111 held, owner pulses `done` 2 cycles after each grant → grant sequence 001, 010, 100, 001, with an idle cycle between each grant.
- `req`=3'b100 after reset, `done[2]` one cycle later; then `req`=3'b101 → grants are 100 then 001, showing wrap to `ptr`=0.
- Owner 1 holds the grant while `req[0]` rises; `done[1]` follows 3 cycles later → `gnt` stays 010 until release, then 001 after one idle cycle.
- `reset_n` pulled low mid-grant (`gnt`=010) → `gnt`=0 with no clock edge; after release, `req`=3'b011 → `gnt`=001.
- With `RR_ARB_TIMEOUT_EN` and MAX_HOLD=4: `req`=3'b001 held and `done`=0 → `gnt`=001 for exactly 4 cycles, `expired`=1 for 1 cycle, then a re-grant to 001 after one idle cycle.
